muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer and HI/LO owner for the multiply and divide units.
//  - Accepts a MULT/DIV request from the control unit.
//  - Launches the selected unit with a 1-cycle start pulse and holds the CPU via busy.
//  - Commits the unit's hi/lo results into the architectural HI/LO registers.
//  - Sits between the control unit/register bank and the Multi/Div datapaths.
// PARAMETERS
//  WIDTH    32  operand and result width
//  TIMEOUT  64  max WAIT cycles before abort
//  CNT_W     7  timeout counter width (must satisfy 2**CNT_W > TIMEOUT)
// PORTS
//  clock     in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-high; clears all state
//  req       in   1      issue request; sampled only when busy=0
//  op        in   1      0=MULT, 1=DIV (sampled with req)
//  a, b      in   WIDTH  operands (sampled with req)
//  flush     in   1      synchronous abort of the in-flight operation
//  hi_we     in   1      MTHI write enable
//  lo_we     in   1      MTLO write enable
//  wdata     in   WIDTH  MTHI/MTLO data
//  busy      out  1      operation in flight (LAUNCH or WAIT)
//  done      out  1      1-cycle pulse: result committed to HI/LO
//  timeout   out  1      1-cycle pulse: unit failed to finish
//  div0      out  1      1-cycle pulse: divide by zero (macro only; else tied 0)
//  hi, lo    out  WIDTH  architectural HI/LO registers
//  mul_start out  1      start pulse to multiplier
//  div_start out  1      start pulse to divider
//  opa, opb  out  WIDTH  latched operands; stable from LAUNCH until IDLE
//  mul_hi, mul_lo, div_hi, div_lo   in  WIDTH  unit results
//  mul_done, div_done               in  1      unit completion, level or pulse
// BEHAVIOUR
//  Reset (async): state=IDLE, counter=0, all outputs 0 (incl. hi, lo, opa, opb).
//  States: IDLE -> LAUNCH -> WAIT -> IDLE. Encoding is 2 bits.
//  IDLE: on edge with req=1, latch op/a/b into opa/opb, go to LAUNCH.
//  LAUNCH: exactly one cycle; busy=1.
//   - Assert mul_start (op=0) or div_start (op=1), never both.
//   - Clear counter, go to WAIT.
//  WAIT: busy=1; counter increments each cycle.
//   - Only the selected unit's done is observed; the other unit's done is ignored.
//   - On an edge with selected done=1: hi/lo <= selected unit's hi/lo, go to IDLE.
//     In the following cycle done=1 and busy=0.
//   - If counter == TIMEOUT-1 with no done: go to IDLE, timeout=1 next cycle,
//     HI/LO unchanged.
//  Latency: req edge N -> start high in cycle N+1 -> earliest done pulse cycle N+3.
//  Back-to-back: req is accepted in the same cycle done/timeout is high (busy=0).
//  req while busy=1: ignored, not queued; the requester must hold until busy=0.
//  flush=1 (any state except IDLE):
//   - Next state IDLE, no done/timeout pulse, HI/LO unchanged.
//   - flush has priority over a same-edge unit done.
//   - flush in IDLE is a no-op; req with flush in IDLE is discarded.
//  hi_we/lo_we: write wdata only when busy=0; ignored while busy=1.
//   - Same-edge req and write in IDLE: both take effect; the later commit overwrites.
//  Reset mid-operation: immediate return to IDLE; start lines drop asynchronously.
//   The units share this reset.
// CONFIGURATION
//  DIV0_TRAP_EN defined: op=1 with b==0 at the req edge is not launched.
//   - State stays IDLE, div0=1 the next cycle, HI/LO unchanged, no done pulse.
//  DIV0_TRAP_EN undefined: div0 tied 0; the divide is launched normally and the
//   divider's result is committed as-is.
// TESTING
//  MULT a=7,b=-3 -> mul_start 1 cycle; after mul_done, hi=32'hFFFFFFFF,
//   lo=32'hFFFFFFEB, done 1 cycle.
//  DIV a=100,b=7 -> div_start only; on div_done, hi=2, lo=14.
//   A spurious mul_done during WAIT has no effect.
//  DIV b=0: with macro -> div0 pulse, no div_start, HI/LO kept.
//   Without macro -> div_start issued.
//  Unit done never arrives -> timeout pulse exactly TIMEOUT cycles after LAUNCH,
//   busy falls, HI/LO kept.
//  flush on the same edge as mul_done -> no done, HI/LO kept.
//   A subsequent req is accepted the next cycle.
//  reset asserted mid-WAIT -> all outputs 0 immediately.
//   hi_we during busy is ignored; hi_we in IDLE with wdata=32'h1234 -> hi=32'h1234.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: launches one unit per request, owns HI/LO and watches for a hung unit.
// Optional DIV0_TRAP_EN: a divide by zero is trapped at issue and reported on div0 instead of launched.
module muldiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mul_start,
  output logic             div_start,
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  input  logic             mul_done,
  input  logic             div_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t           state;
  logic             op_sel;
  logic [CNT_W-1:0] count;

  logic             sel_done;
  logic [WIDTH-1:0] sel_hi;
  logic [WIDTH-1:0] sel_lo;
  logic             div0_trap;

  // Only the unit that was launched is listened to.
  assign sel_done = op_sel ? div_done : mul_done;
  assign sel_hi   = op_sel ? div_hi   : mul_hi;
  assign sel_lo   = op_sel ? div_lo   : mul_lo;

`ifdef DIV0_TRAP_EN
  assign div0_trap = op && (b == '0);
`else
  assign div0_trap = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_sel    <= 1'b0;
      count     <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      div0      <= 1'b0;
      mul_start <= 1'b0;
      div_start <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      opa       <= '0;
      opb       <= '0;
    end else begin
      done      <= 1'b0;
      timeout   <= 1'b0;
      div0      <= 1'b0;
      mul_start <= 1'b0;
      div_start <= 1'b0;

      // MTHI/MTLO only land while idle; a commit later in the same op overwrites them.
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end

      case (state)
        IDLE: begin
          if (req && !flush) begin
            if (div0_trap) begin
              div0 <= 1'b1;
            end else begin
              op_sel    <= op;
              opa       <= a;
              opb       <= b;
              mul_start <= !op;
              div_start <= op;
              state     <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            count <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (sel_done) begin
            hi    <= sel_hi;
            lo    <= sel_lo;
            done  <= 1'b1;
            state <= IDLE;
          end else if (count == CNT_W'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table of full operations plus hand-written corner sequences.
// Expectations for the divide-by-zero case follow the DIV0_TRAP_EN build setting.
module tb_muldiv_ctrl;
  localparam int W  = 32;
  localparam int TO = 64;
  localparam int CW = 7;

  logic         clock = 1'b0;
  logic         reset;
  logic         req, op, flush, hi_we, lo_we;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, timeout, div0;
  logic [W-1:0] hi, lo, opa, opb;
  logic         mul_start, div_start;
  logic [W-1:0] mul_hi, mul_lo, div_hi, div_lo;
  logic         mul_done, div_done;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_hi, m_lo;

  muldiv_ctrl #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .req(req), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .timeout(timeout), .div0(div0),
    .hi(hi), .lo(lo), .mul_start(mul_start), .div_start(div_start),
    .opa(opa), .opb(opb), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_hi(div_hi), .div_lo(div_lo), .mul_done(mul_done), .div_done(div_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         op;
    logic [W-1:0] a, b, mhi, mlo, dhi, dlo;
    int           delay;
    logic         spur;
    logic [W-1:0] ehi, elo;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    req = 1'b1; op = v.op; a = v.a; b = v.b;
    mul_hi = v.mhi; mul_lo = v.mlo; div_hi = v.dhi; div_lo = v.dlo;
    tick;
    req = 1'b0;
    chk($sformatf("v%0d_launch_busy", idx), busy, 1);
    chk($sformatf("v%0d_mul_start", idx), mul_start, !v.op);
    chk($sformatf("v%0d_div_start", idx), div_start, v.op);
    chk($sformatf("v%0d_opa", idx), opa, v.a);
    chk($sformatf("v%0d_opb", idx), opb, v.b);
    tick;
    chk($sformatf("v%0d_start_drop", idx), {mul_start, div_start}, 0);
    if (v.spur) begin
      if (v.op) mul_done = 1'b1;
      else      div_done = 1'b1;
    end
    for (int i = 0; i < v.delay; i++) begin
      tick;
      chk($sformatf("v%0d_wait_busy", idx), busy, 1);
      chk($sformatf("v%0d_no_early_done", idx), done, 0);
    end
    if (v.op) div_done = 1'b1;
    else      mul_done = 1'b1;
    tick;
    mul_done = 1'b0; div_done = 1'b0;
    chk($sformatf("v%0d_done", idx), done, 1);
    chk($sformatf("v%0d_busy_low", idx), busy, 0);
    chk($sformatf("v%0d_hi", idx), hi, v.ehi);
    chk($sformatf("v%0d_lo", idx), lo, v.elo);
    m_hi = v.ehi; m_lo = v.elo;
    tick;
    chk($sformatf("v%0d_done_pulse", idx), done, 0);
    $display("vec %0d op=%0d a=%h b=%h delay=%0d spur=%0d -> hi=%h lo=%h", idx, v.op, v.a, v.b, v.delay, v.spur, hi, lo);
  endtask

  initial begin
    int seen;
    vecs[0] = '{1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'hDEAD0001, 32'hDEAD0002, 0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{1'b1, 32'd100, 32'd7, 32'h11111111, 32'h22222222, 32'd2, 32'd14, 3, 1'b1, 32'd2, 32'd14};
    vecs[2] = '{1'b0, 32'h10000, 32'h10000, 32'd1, 32'd0, 32'h33333333, 32'h44444444, 5, 1'b1, 32'd1, 32'd0};
    vecs[3] = '{1'b1, 32'hFFFFFFF7, 32'd2, 32'h55555555, 32'h66666666, 32'hFFFFFFFF, 32'hFFFFFFFC, 1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFC};
    vecs[4] = '{1'b0, 32'h7FFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 32'h77777777, 32'h88888888, 10, 1'b0, 32'd0, 32'hFFFFFFFE};

    reset = 1'b0; req = 0; op = 0; a = 0; b = 0; flush = 0; hi_we = 0; lo_we = 0; wdata = 0;
    mul_hi = 0; mul_lo = 0; div_hi = 0; div_lo = 0; mul_done = 0; div_done = 0;
    #1 reset = 1'b1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_flags", {done, timeout, div0, mul_start, div_start}, 0);
    tick;
    reset = 1'b0;
    tick;
    chk("post_rst_idle", {busy, done, mul_start, div_start}, 0);
    m_hi = 0; m_lo = 0;
    $display("reset: outputs cleared");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Timeout: no unit done ever arrives.
    req = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
    tick;
    req = 1'b0;
    seen = -1;
    for (int n = 1; n <= TO + 4; n++) begin
      tick;
      if (timeout === 1'b1) begin
        seen = n;
        break;
      end
    end
    chk("timeout_cycle", seen, TO + 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_done", done, 0);
    chk("timeout_hi", hi, m_hi);
    chk("timeout_lo", lo, m_lo);
    // Back-to-back: request accepted during the timeout cycle.
    req = 1'b1; op = 1'b0; a = 32'd5; b = 32'd6; mul_hi = 32'd9; mul_lo = 32'd10;
    tick;
    req = 1'b0;
    chk("b2b_start", mul_start, 1);
    chk("timeout_pulse_end", timeout, 0);
    tick;
    mul_done = 1'b1;
    tick;
    mul_done = 1'b0;
    chk("b2b_done", done, 1);
    chk("b2b_hi", hi, 32'd9);
    chk("b2b_lo", lo, 32'd10);
    m_hi = 32'd9; m_lo = 32'd10;
    tick;
    $display("timeout: pulse at cycle %0d after launch", seen);

    // Flush on the same edge as mul_done.
    req = 1'b1; op = 1'b0; a = 32'd2; b = 32'd2;
    tick;
    req = 1'b0;
    tick;
    mul_hi = 32'hAAAA; mul_lo = 32'hBBBB; mul_done = 1'b1; flush = 1'b1;
    tick;
    flush = 1'b0; mul_done = 1'b0;
    chk("flush_no_done", done, 0);
    chk("flush_busy", busy, 0);
    chk("flush_hi", hi, m_hi);
    chk("flush_lo", lo, m_lo);
    req = 1'b1; op = 1'b1; a = 32'd50; b = 32'd5; div_hi = 32'd0; div_lo = 32'd10;
    tick;
    req = 1'b0;
    chk("after_flush_busy", busy, 1);
    chk("after_flush_div_start", div_start, 1);
    tick;
    div_done = 1'b1;
    tick;
    div_done = 1'b0;
    chk("after_flush_done", done, 1);
    chk("after_flush_hi", hi, 32'd0);
    chk("after_flush_lo", lo, 32'd10);
    m_hi = 32'd0; m_lo = 32'd10;
    tick;
    $display("flush: same-edge done suppressed, next req accepted");

    // req with flush in IDLE is discarded.
    req = 1'b1; flush = 1'b1; op = 1'b0;
    tick;
    req = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", busy, 0);
    chk("idle_flush_start", mul_start, 0);
    tick;
    chk("idle_flush_not_queued", busy, 0);
    $display("idle flush: req discarded");

    // req while busy is ignored, not queued.
    req = 1'b1; op = 1'b0; a = 32'd1; b = 32'd2;
    tick;
    req = 1'b0;
    tick;
    req = 1'b1; op = 1'b1; a = 32'd9; b = 32'd9;
    tick;
    req = 1'b0;
    chk("busy_req_opa", opa, 32'd1);
    chk("busy_req_no_start", div_start, 0);
    mul_hi = 32'd5; mul_lo = 32'd6; mul_done = 1'b1;
    tick;
    mul_done = 1'b0;
    chk("busy_req_done", done, 1);
    chk("busy_req_hi", hi, 32'd5);
    tick;
    chk("busy_req_not_queued", busy, 0);
    m_hi = 32'd5; m_lo = 32'd6;
    $display("busy req: ignored");

    // MTHI during busy is ignored, MTHI/MTLO in IDLE take effect.
    req = 1'b1; op = 1'b0; a = 32'd3; b = 32'd3;
    tick;
    req = 1'b0; hi_we = 1'b1; wdata = 32'hDEAD;
    tick;
    hi_we = 1'b0;
    chk("busy_hi_we", hi, m_hi);
    mul_hi = 32'd7; mul_lo = 32'd8; mul_done = 1'b1;
    tick;
    mul_done = 1'b0;
    chk("hiwe_op_hi", hi, 32'd7);
    hi_we = 1'b1; wdata = 32'h1234;
    tick;
    hi_we = 1'b0;
    chk("idle_hi_we", hi, 32'h1234);
    chk("idle_hi_we_lo", lo, 32'd8);
    lo_we = 1'b1; wdata = 32'h5678;
    tick;
    lo_we = 1'b0;
    chk("idle_lo_we", lo, 32'h5678);
    $display("mthi/mtlo: hi=%h lo=%h", hi, lo);

    // Same-edge req and MTHI: write lands, then commit overwrites.
    req = 1'b1; op = 1'b0; a = 32'd4; b = 32'd4; hi_we = 1'b1; wdata = 32'h55;
    tick;
    req = 1'b0; hi_we = 1'b0;
    chk("same_edge_write", hi, 32'h55);
    chk("same_edge_start", mul_start, 1);
    tick;
    mul_hi = 32'h66; mul_lo = 32'h77; mul_done = 1'b1;
    tick;
    mul_done = 1'b0;
    chk("same_edge_commit_hi", hi, 32'h66);
    chk("same_edge_commit_lo", lo, 32'h77);
    m_hi = 32'h66; m_lo = 32'h77;
    tick;
    $display("same-edge req+write: hi=%h", hi);

    // Divide by zero.
    req = 1'b1; op = 1'b1; a = 32'd10; b = 32'd0;
    tick;
    req = 1'b0;
`ifdef DIV0_TRAP_EN
    chk("div0_busy", busy, 0);
    chk("div0_no_start", div_start, 0);
    chk("div0_pulse", div0, 1);
    chk("div0_hi", hi, m_hi);
    tick;
    chk("div0_pulse_end", div0, 0);
    chk("div0_no_done", done, 0);
`else
    chk("div0_start", div_start, 1);
    chk("div0_busy", busy, 1);
    chk("div0_tied", div0, 0);
    tick;
    div_hi = 32'd10; div_lo = 32'hFFFFFFFF; div_done = 1'b1;
    tick;
    div_done = 1'b0;
    chk("div0_done", done, 1);
    chk("div0_hi", hi, 32'd10);
    chk("div0_lo", lo, 32'hFFFFFFFF);
    m_hi = 32'd10; m_lo = 32'hFFFFFFFF;
    tick;
`endif
    $display("div by zero: hi=%h lo=%h", hi, lo);

    // Reset asserted mid-WAIT clears everything immediately.
    req = 1'b1; op = 1'b0; a = 32'h11; b = 32'h22;
    tick;
    req = 1'b0;
    tick;
    #1 reset = 1'b1;
    #1;
    chk("midwait_rst_busy", busy, 0);
    chk("midwait_rst_hi", hi, 0);
    chk("midwait_rst_lo", lo, 0);
    chk("midwait_rst_opa", opa, 0);
    chk("midwait_rst_opb", opb, 0);
    chk("midwait_rst_flags", {done, timeout, div0, mul_start, div_start}, 0);
    reset = 1'b0;
    tick;
    chk("midwait_rst_idle", busy, 0);
    $display("reset mid-wait: outputs cleared");

    // Reset during LAUNCH drops the start line without waiting for a clock.
    req = 1'b1; op = 1'b0; a = 32'h3; b = 32'h3;
    tick;
    req = 1'b0;
    chk("launch_start_high", mul_start, 1);
    reset = 1'b1;
    #1;
    chk("launch_rst_start", mul_start, 0);
    reset = 1'b0;
    tick;
    chk("launch_rst_idle", busy, 0);
    $display("reset in launch: start dropped");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
